// File: rtl/layer0_pkg.sv
// Shared constants, state encoding and helper functions for the layer-0 write-back path.
package layer0_pkg;

  localparam int CONV_W    = 19;
  localparam int DATA_W    = 20;
  localparam int ADDR_W    = 12;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;

  localparam logic [1:0] CSEL_NONE = 2'd0;
  localparam logic [1:0] CSEL_L0   = 2'd1;
  localparam logic [1:0] CSEL_L1   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ROW   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  function automatic logic [DATA_W-1:0] relu(input logic [CONV_W-1:0] d);
    logic [DATA_W-1:0] r;
    if (d[CONV_W-1]) r = '0;
    else r = {1'b0, d};
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] m;
    if (a > b) m = a;
    else m = b;
    return m;
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// One row of 2x2 pooling partial results: a read-modify-write port fed during
// the pixel stream and an independent read port used while draining to L1.
module pool_row_buf
  import layer0_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W / 2,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rmw_en_i,
  input  logic [IDX_W-1:0]  rmw_idx_i,
  input  logic              rmw_merge_i,
  input  logic [DATA_W-1:0] rmw_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] old_s;
  logic [DATA_W-1:0] new_s;

  assign old_s     = mem_q[rmw_idx_i];
  assign rd_data_o = mem_q[rd_idx_i];

  // Odd rows fold into the value the even row left behind.
  always_comb begin
    new_s = rmw_data_i;
    if (rmw_merge_i) new_s = max_u(old_s, rmw_data_i);
    else new_s = rmw_data_i;
  end

  always_ff @(posedge clk) begin
    if (rmw_en_i) mem_q[rmw_idx_i] <= new_s;
  end

endmodule

// File: rtl/layer0_writer.sv
// Layer-0 write-back: ReLU, L0 writes, row pacing via o_go_down.
// 2x2 max-pooling into L1 is built only when LAYER0_WRITER_POOL_EN is defined.
module layer0_writer
  import layer0_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [CONV_W-1:0] i_data,
  output logic              o_go_down,
  output logic [1:0]        o_csel,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                we_q, we_d;
  logic [1:0]          csel_q, csel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                go_down_q, go_down_d;
  logic                done_q, done_d;
  logic                busy_q;

  logic [DATA_W-1:0]   relu_s;
  logic                accept_s;
  logic                last_col_s;
  logic                last_row_s;

  assign relu_s     = relu(i_data);
  assign accept_s   = i_valid && ((state_q == ST_IDLE) || (state_q == ST_ROW));
  assign last_col_s = (col_q == COL_W'(IMG_W - 1));
  assign last_row_s = (row_q == ROW_W'(IMG_H - 1));

`ifdef LAYER0_WRITER_POOL_EN
  localparam int HALF_W = IMG_W / 2;
  localparam int IDX_W  = COL_W - 1;

  logic [DATA_W-1:0]   pair_q, pair_d;
  logic [IDX_W-1:0]    drain_q, drain_d;
  logic [DATA_W-1:0]   pmax_s;
  logic [DATA_W-1:0]   rd_data_s;

  assign pmax_s = max_u(pair_q, relu_s);

  pool_row_buf #(.DEPTH(HALF_W), .IDX_W(IDX_W)) u_pbuf (
    .clk         (clk),
    .rmw_en_i    (accept_s && col_q[0]),
    .rmw_idx_i   (col_q[COL_W-1:1]),
    .rmw_merge_i (row_q[0]),
    .rmw_data_i  (pmax_s),
    .rd_idx_i    (drain_q),
    .rd_data_o   (rd_data_s)
  );
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    we_d      = 1'b0;
    csel_d    = CSEL_NONE;
    addr_d    = '0;
    wdata_d   = '0;
    go_down_d = 1'b0;
    done_d    = 1'b0;
`ifdef LAYER0_WRITER_POOL_EN
    pair_d    = pair_q;
    drain_d   = drain_q;
`endif
    if (accept_s) begin
      we_d    = 1'b1;
      csel_d  = CSEL_L0;
      addr_d  = ADDR_W'({row_q, col_q});
      wdata_d = relu_s;
      col_d   = col_q + COL_W'(1);
`ifdef LAYER0_WRITER_POOL_EN
      if (!col_q[0]) pair_d = relu_s;
      else pair_d = pair_q;
`endif
      if (last_col_s) begin
`ifdef LAYER0_WRITER_POOL_EN
        // IMG_H is even, so the last row is always odd and leaves through DRAIN.
        if (row_q[0]) state_d = ST_DRAIN;
        else state_d = ST_HOLD;
`else
        if (last_row_s) state_d = ST_FIN;
        else state_d = ST_HOLD;
`endif
      end else begin
        state_d = ST_ROW;
      end
    end else begin
      case (state_q)
`ifdef LAYER0_WRITER_POOL_EN
        ST_DRAIN: begin
          we_d    = 1'b1;
          csel_d  = CSEL_L1;
          addr_d  = ADDR_W'({row_q[ROW_W-1:1], drain_q});
          wdata_d = rd_data_s;
          drain_d = drain_q + IDX_W'(1);
          if (drain_q == IDX_W'(HALF_W - 1)) begin
            if (last_row_s) state_d = ST_FIN;
            else state_d = ST_HOLD;
          end else begin
            state_d = ST_DRAIN;
          end
        end
`endif
        ST_HOLD: begin
          go_down_d = 1'b1;
          row_d     = row_q + ROW_W'(1);
          state_d   = ST_ROW;
        end
        ST_FIN: begin
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      we_q      <= 1'b0;
      csel_q    <= CSEL_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      go_down_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef LAYER0_WRITER_POOL_EN
      pair_q    <= '0;
      drain_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      we_q      <= we_d;
      csel_q    <= csel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      go_down_q <= go_down_d;
      done_q    <= done_d;
      busy_q    <= (state_d != ST_IDLE);
`ifdef LAYER0_WRITER_POOL_EN
      pair_q    <= pair_d;
      drain_q   <= drain_d;
`endif
    end
  end

  assign o_go_down = go_down_q;
  assign o_csel    = csel_q;
  assign o_we      = we_q;
  assign o_addr    = addr_q;
  assign o_wdata   = wdata_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_layer0_writer.sv
// Directed bench for layer0_writer; pooling scenarios follow LAYER0_WRITER_POOL_EN.
module tb_layer0_writer;

  localparam int W = 64;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [18:0] i_data = '0;
  logic        o_go_down, o_we, o_busy, o_done;
  logic [1:0]  o_csel;
  logic [11:0] o_addr;
  logic [19:0] o_wdata;

  layer0_writer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_go_down(o_go_down), .o_csel(o_csel), .o_we(o_we), .o_addr(o_addr),
    .o_wdata(o_wdata), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  wr_csel[$];
  logic [11:0] wr_addr[$];
  logic [19:0] wr_data[$];
  int          wr_cyc[$];
  int          go_cyc[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    if (o_we === 1'b1) begin
      wr_csel.push_back(o_csel);
      wr_addr.push_back(o_addr);
      wr_data.push_back(o_wdata);
      wr_cyc.push_back(cyc);
    end
    if (o_go_down === 1'b1) go_cyc.push_back(cyc);
    if (o_done === 1'b1) done_cyc.push_back(cyc);
  end

  function automatic int pix_val(input int mode, input int r, input int c);
    case (mode)
      0: return c - 32;
      1: return c;
      2: return 63 - c;
      3: return (c % 2 == 1) ? -1 : -262144;
      4: return r * 5 + c * 3 - 150;
      default: return 0;
    endcase
  endfunction

  function automatic int relu_i(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_csel.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    go_cyc.delete(); done_cyc.delete();
  endtask

  task automatic send_row(input int mode, input int r, input bit gaps);
    for (int c = 0; c < W; c++) begin
      i_valid = 1'b1;
      i_data  = 19'(pix_val(mode, r, c));
      @(negedge clk);
      if (gaps && (c < W - 1) && ($urandom_range(3) == 0)) idle($urandom_range(3, 1));
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_go(input int budget);
    int k = 0;
    while (o_go_down !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (o_go_down !== 1'b1) begin
      n_bad++;
      $display("FAIL go_down_timeout: got no pulse within %0d cycles, required a pulse", budget);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (o_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_timeout: got no pulse within %0d cycles, required a pulse", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_valid = 1'b1;
    i_data = 19'd5;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_we, o_csel, o_addr, o_wdata, o_go_down, o_busy, o_done} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b csel=%0d addr=%0d wdata=%0d go=%b busy=%b done=%b, required all 0",
               o_we, o_csel, o_addr, o_wdata, o_go_down, o_busy, o_done);
    end
    do_reset();
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy: got %b required 0", o_busy);
    end
  endtask

  task automatic test_single_row();
    int exp_d;
    do_reset();
    send_row(0, 0, 1'b0);
    wait_go(8);
    idle(2);
    n_cmp++;
    if (wr_addr.size() != 64) begin
      n_bad++;
      $display("FAIL row_write_count: got %0d required 64", wr_addr.size());
    end
    for (int k = 0; k < wr_addr.size() && k < 64; k++) begin
      exp_d = (k > 32) ? k - 32 : 0;
      n_cmp++;
      if (wr_csel[k] !== 2'd1 || wr_addr[k] !== 12'(k) || wr_data[k] !== 20'(exp_d)) begin
        n_bad++;
        $display("FAIL row_write[%0d]: got csel=%0d addr=%0d data=%0d required csel=1 addr=%0d data=%0d",
                 k, wr_csel[k], wr_addr[k], wr_data[k], k, exp_d);
      end
    end
    if (wr_cyc.size() == 64) begin
      n_cmp++;
      if (wr_cyc[63] - wr_cyc[0] != 63) begin
        n_bad++;
        $display("FAIL back_to_back: got span %0d required 63", wr_cyc[63] - wr_cyc[0]);
      end
      n_cmp++;
      if (go_cyc.size() != 1 || go_cyc[0] != wr_cyc[63] + 1) begin
        n_bad++;
        $display("FAIL go_down_timing: got %0d pulses first at %0d required 1 at %0d",
                 go_cyc.size(), (go_cyc.size() > 0) ? go_cyc[0] : -1, wr_cyc[63] + 1);
      end
    end
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_mid_image: got %b required 1", o_busy);
    end
  endtask

  task automatic test_negative();
    int n_l1;
    do_reset();
    send_row(3, 0, 1'b0);
    wait_go(8);
`ifdef LAYER0_WRITER_POOL_EN
    send_row(3, 1, 1'b0);
    wait_go(60);
`endif
    idle(2);
    n_l1 = 0;
    for (int k = 0; k < wr_data.size(); k++) begin
      if (wr_csel[k] == 2'd2) n_l1++;
      n_cmp++;
      if (wr_data[k] !== 20'd0) begin
        n_bad++;
        $display("FAIL negative_relu[%0d]: got %0d required 0", k, wr_data[k]);
      end
    end
    n_cmp++;
`ifdef LAYER0_WRITER_POOL_EN
    if (wr_data.size() != 160 || n_l1 != 32) begin
      n_bad++;
      $display("FAIL negative_count: got %0d writes %0d L1 required 160 writes 32 L1", wr_data.size(), n_l1);
    end
`else
    if (wr_data.size() != 64 || n_l1 != 0) begin
      n_bad++;
      $display("FAIL negative_count: got %0d writes %0d L1 required 64 writes 0 L1", wr_data.size(), n_l1);
    end
`endif
  endtask

`ifdef LAYER0_WRITER_POOL_EN
  task automatic check_two_row_pool(input string nm, input int exp_l0);
    int l0[$];
    int l1[$];
    int exp_d;
    foreach (wr_csel[k]) begin
      if (wr_csel[k] == 2'd1) l0.push_back(k);
      else if (wr_csel[k] == 2'd2) l1.push_back(k);
    end
    n_cmp++;
    if (l0.size() != exp_l0 || l1.size() != 32) begin
      n_bad++;
      $display("FAIL %s_counts: got L0=%0d L1=%0d required L0=%0d L1=32", nm, l0.size(), l1.size(), exp_l0);
    end
    for (int j = 0; j < l1.size() && j < 32; j++) begin
      exp_d = (2 * j + 1 > 63 - 2 * j) ? 2 * j + 1 : 63 - 2 * j;
      n_cmp++;
      if (wr_addr[l1[j]] !== 12'(j) || wr_data[l1[j]] !== 20'(exp_d)) begin
        n_bad++;
        $display("FAIL %s_l1[%0d]: got addr=%0d data=%0d required addr=%0d data=%0d",
                 nm, j, wr_addr[l1[j]], wr_data[l1[j]], j, exp_d);
      end
    end
    if (l1.size() == 32 && l0.size() >= 128) begin
      n_cmp++;
      if (wr_cyc[l1[0]] != wr_cyc[l0[127]] + 1 || wr_cyc[l1[31]] - wr_cyc[l1[0]] != 31) begin
        n_bad++;
        $display("FAIL %s_drain_window: got start=%0d end=%0d required start=%0d end=%0d", nm,
                 wr_cyc[l1[0]], wr_cyc[l1[31]], wr_cyc[l0[127]] + 1, wr_cyc[l0[127]] + 32);
      end
      n_cmp++;
      if (go_cyc.size() != 2 || go_cyc[1] != wr_cyc[l1[31]] + 1) begin
        n_bad++;
        $display("FAIL %s_go_after_drain: got %0d pulses required 2 with last at %0d", nm,
                 go_cyc.size(), wr_cyc[l1[31]] + 1);
      end
    end
  endtask

  task automatic test_pool_two_rows();
    do_reset();
    send_row(1, 0, 1'b0);
    wait_go(8);
    send_row(2, 1, 1'b0);
    wait_go(60);
    idle(2);
    check_two_row_pool("pool2", 128);
  endtask

  task automatic test_drain_violation();
    do_reset();
    send_row(1, 0, 1'b0);
    wait_go(8);
    send_row(2, 1, 1'b0);
    i_valid = 1'b1;
    i_data = 19'd1000;
    repeat (3) @(negedge clk);
    i_valid = 1'b0;
    wait_go(60);
    i_valid = 1'b1;
    i_data = 19'd7;
    @(negedge clk);
    idle(2);
    check_two_row_pool("violation", 129);
    n_cmp++;
    if (wr_addr.size() == 0 || wr_addr[$] !== 12'd128 || wr_data[$] !== 20'd7 || wr_csel[$] !== 2'd1) begin
      n_bad++;
      $display("FAIL violation_next_row: got last write addr=%0d data=%0d required addr=128 data=7",
               (wr_addr.size() > 0) ? wr_addr[$] : 12'd0, (wr_data.size() > 0) ? wr_data[$] : 20'd0);
    end
  endtask
`endif

  task automatic test_full_image();
    int l0[$];
    int l1[$];
    int exp_d;
    int r;
    int c;
    do_reset();
    for (int rr = 0; rr < H; rr++) begin
      send_row(4, rr, 1'b1);
      if (rr < H - 1) wait_go(100);
      else wait_done(100);
    end
    idle(3);
    foreach (wr_csel[k]) begin
      if (wr_csel[k] == 2'd1) l0.push_back(k);
      else if (wr_csel[k] == 2'd2) l1.push_back(k);
    end
    n_cmp++;
    if (l0.size() != 4096) begin
      n_bad++;
      $display("FAIL full_l0_count: got %0d required 4096", l0.size());
    end
    for (int k = 0; k < l0.size() && k < 4096; k++) begin
      exp_d = relu_i(pix_val(4, k / W, k % W));
      n_cmp++;
      if (wr_addr[l0[k]] !== 12'(k) || wr_data[l0[k]] !== 20'(exp_d)) begin
        n_bad++;
        $display("FAIL full_l0[%0d]: got addr=%0d data=%0d required addr=%0d data=%0d",
                 k, wr_addr[l0[k]], wr_data[l0[k]], k, exp_d);
      end
    end
`ifdef LAYER0_WRITER_POOL_EN
    n_cmp++;
    if (l1.size() != 1024) begin
      n_bad++;
      $display("FAIL full_l1_count: got %0d required 1024", l1.size());
    end
    for (int j = 0; j < l1.size() && j < 1024; j++) begin
      r = 2 * (j / 32);
      c = 2 * (j % 32);
      exp_d = relu_i(pix_val(4, r, c));
      if (relu_i(pix_val(4, r, c + 1)) > exp_d) exp_d = relu_i(pix_val(4, r, c + 1));
      if (relu_i(pix_val(4, r + 1, c)) > exp_d) exp_d = relu_i(pix_val(4, r + 1, c));
      if (relu_i(pix_val(4, r + 1, c + 1)) > exp_d) exp_d = relu_i(pix_val(4, r + 1, c + 1));
      n_cmp++;
      if (wr_addr[l1[j]] !== 12'(j) || wr_data[l1[j]] !== 20'(exp_d)) begin
        n_bad++;
        $display("FAIL full_l1[%0d]: got addr=%0d data=%0d required addr=%0d data=%0d",
                 j, wr_addr[l1[j]], wr_data[l1[j]], j, exp_d);
      end
    end
    n_cmp++;
    if (l1.size() == 0 || wr_addr[l1[$]] !== 12'd1023) begin
      n_bad++;
      $display("FAIL full_last_l1_addr: got %0d required 1023", (l1.size() > 0) ? wr_addr[l1[$]] : 12'd0);
    end
`else
    n_cmp++;
    if (l1.size() != 0) begin
      n_bad++;
      $display("FAIL full_l1_count: got %0d required 0", l1.size());
    end
`endif
    n_cmp++;
    if (go_cyc.size() != 63) begin
      n_bad++;
      $display("FAIL full_go_count: got %0d required 63", go_cyc.size());
    end
    n_cmp++;
    if (done_cyc.size() != 1 || wr_cyc.size() == 0 || done_cyc[0] != wr_cyc[$] + 1) begin
      n_bad++;
      $display("FAIL full_done: got %0d pulses first at %0d required 1 at %0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1, (wr_cyc.size() > 0) ? wr_cyc[$] + 1 : -1);
    end
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL full_busy_after_done: got %b required 0", o_busy);
    end
  endtask

  task automatic test_reset_mid_row();
    do_reset();
    for (int rr = 0; rr < 5; rr++) begin
      send_row(1, rr, 1'b0);
      wait_go(60);
    end
    for (int c = 0; c < 17; c++) begin
      i_valid = 1'b1;
      i_data = 19'(c + 1);
      @(negedge clk);
    end
    reset = 1'b1;
    i_data = 19'd5;
    @(negedge clk);
    n_cmp++;
    if (o_we !== 1'b0 || o_busy !== 1'b0 || o_go_down !== 1'b0 || o_csel !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got we=%b busy=%b go=%b csel=%0d required all 0",
               o_we, o_busy, o_go_down, o_csel);
    end
    reset = 1'b0;
    idle(2);
    wr_csel.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    i_valid = 1'b1;
    i_data = 19'd9;
    @(negedge clk);
    idle(2);
    n_cmp++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 12'd0 || wr_data[0] !== 20'd9 || wr_csel[0] !== 2'd1) begin
      n_bad++;
      $display("FAIL restart_addr: got %0d writes first addr=%0d data=%0d required 1 write addr=0 data=9",
               wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 12'd0, (wr_data.size() > 0) ? wr_data[0] : 20'd0);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_negative();
`ifdef LAYER0_WRITER_POOL_EN
    test_pool_two_rows();
    test_drain_violation();
`endif
    test_full_image();
    test_reset_mid_row();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
